// File: rtl/rd_arb_pkg.sv
// Shared types and constants for the AXI4-Lite read arbiter.
package rd_arb_pkg;

  // Arbiter transaction phases; one outstanding read at a time.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  // Requester identity, also the encoding of arb_owner.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // AXI read response codes; the arbiter passes them through untouched.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Single-beat AXI4-Lite read channel (AR + R) bundle.
//
// Handshake rules for both channels: a beat transfers on the rising clock
// edge where valid and ready are both 1. valid never waits on ready; once
// valid is raised, valid and its payload stay stable until that transfer.
// ready may be raised before, with or after valid.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  // Side that issues reads.
  modport master (
    output araddr, arvalid, rready,
    input  arready, rvalid, rdata, rresp
  );

  // Side that serves reads.
  modport slave (
    input  araddr, arvalid, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/rd_arb_pick.sv
// Combinational grant selection between the IFU and LSU read requests.
// Macro RD_ARB_RR_EN selects round-robin; undefined gives fixed LSU priority.
module rd_arb_pick
  import rd_arb_pkg::*;
(
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  input  logic ptr_i,      // last winner (round-robin only)
  output logic grant_o,    // some request is present
  output logic owner_o     // winning requester
);

  assign grant_o = ifu_valid_i | lsu_valid_i;

`ifdef RD_ARB_RR_EN
  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    owner_o = OWN_IFU;
    if (ifu_valid_i && lsu_valid_i) begin
      owner_o = ~ptr_i;
    end else if (lsu_valid_i) begin
      owner_o = OWN_LSU;
    end
  end
`else
  // Fixed priority: the LSU always wins, so the pointer has no role.
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  always_comb begin
    owner_o = OWN_IFU;
    if (lsu_valid_i) begin
      owner_o = OWN_LSU;
    end
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one single-beat AXI4-Lite read channel between the IFU and LSU.
// Reads are serialised (IDLE -> ADDR -> DATA -> RESP); the read data is
// registered before it is returned to the winner.
// Optional macro RD_ARB_RR_EN: round-robin instead of fixed LSU priority.
module axi_rd_arbiter
  import rd_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,     // asynchronous, active low
  axi_rd_arbiter_if.slave       ifu,
  axi_rd_arbiter_if.slave       lsu,
  axi_rd_arbiter_if.master      mem,
  output logic                  arb_busy,
  output logic                  arb_owner,
  output state_e                arb_state  // FSM state for observation
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        resp_q, resp_d;
  logic              owner_q, owner_d;
  logic              ptr;
  logic              grant_any;
  logic              grant_owner;
  logic              resp_valid;
  logic              owner_rready;

  rd_arb_pick u_pick (
    .ifu_valid_i (ifu.arvalid),
    .lsu_valid_i (lsu.arvalid),
    .ptr_i       (ptr),
    .grant_o     (grant_any),
    .owner_o     (grant_owner)
  );

`ifdef RD_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Last-winner pointer, moved on every grant taken in IDLE.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && grant_any) begin
      ptr_d = grant_owner;
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= OWN_IFU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = OWN_IFU;
`endif

  assign owner_rready = (owner_q == OWN_LSU) ? lsu.rready : ifu.rready;

  // Next-state logic and per-phase handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_d      = resp_q;
    owner_d     = owner_q;
    ifu.arready = 1'b0;
    lsu.arready = 1'b0;
    mem.arvalid = 1'b0;
    mem.rready  = 1'b0;
    resp_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // arready is combinational; keep it low while reset is held.
        if (grant_any && reset) begin
          ifu.arready = (grant_owner == OWN_IFU);
          lsu.arready = (grant_owner == OWN_LSU);
          owner_d     = grant_owner;
          addr_d      = (grant_owner == OWN_LSU) ? lsu.araddr : ifu.araddr;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        mem.arvalid = 1'b1;
        if (mem.arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        mem.rready = 1'b1;
        if (mem.rvalid) begin
          data_d  = mem.rdata;
          resp_d  = mem.rresp;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (owner_rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and captured response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      resp_q  <= OKAY;
      owner_q <= OWN_IFU;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      owner_q <= owner_d;
    end
  end

  // Memory address is the latched one, stable for the whole ADDR phase.
  assign mem.araddr = addr_q;

  // Only the owner sees the response; the other requester reads zeros.
  assign ifu.rvalid = resp_valid && (owner_q == OWN_IFU);
  assign lsu.rvalid = resp_valid && (owner_q == OWN_LSU);
  assign ifu.rdata  = (owner_q == OWN_IFU) ? data_q : '0;
  assign lsu.rdata  = (owner_q == OWN_LSU) ? data_q : '0;
  assign ifu.rresp  = (owner_q == OWN_IFU) ? resp_q : OKAY;
  assign lsu.rresp  = (owner_q == OWN_LSU) ? resp_q : OKAY;

  assign arb_busy  = (state_q != IDLE);
  assign arb_owner = owner_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: transaction-level model plus
// directed scenarios (IFU-only, tie, contention, slave stalls, rready
// backpressure with SLVERR, reset during DATA).
module tb_axi_rd_arbiter;
  import rd_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int W  = 66;  // {rresp, rdata}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifu_if ();
  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) lsu_if ();
  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  logic   arb_busy;
  logic   arb_owner;
  state_e arb_state;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .ifu       (ifu_if),
    .lsu       (lsu_if),
    .mem       (mem_if),
    .arb_busy  (arb_busy),
    .arb_owner (arb_owner),
    .arb_state (arb_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  int         ar_wait = 0;
  int         r_wait  = 0;
  logic [1:0] s_resp  = OKAY;
  bit         s_pend  = 0;
  logic [31:0] s_addr = '0;
  int         s_arcnt = 0;
  int         s_rcnt  = 0;

  function automatic logic [63:0] mem_data(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h0000_0013_0000_0093;
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  initial begin
    bit          ar_hs, r_hs;
    logic [31:0] a;
    mem_if.arready = 1'b0;
    mem_if.rvalid  = 1'b0;
    mem_if.rdata   = '0;
    mem_if.rresp   = OKAY;
    forever begin
      @(negedge clock);
      ar_hs = reset && mem_if.arvalid && mem_if.arready;
      r_hs  = reset && mem_if.rvalid && mem_if.rready;
      a     = mem_if.araddr;
      @(posedge clock);
      #1;
      if (!reset) begin
        mem_if.arready = 1'b0;
        mem_if.rvalid  = 1'b0;
        mem_if.rdata   = '0;
        mem_if.rresp   = OKAY;
        s_pend = 0; s_arcnt = 0; s_rcnt = 0;
      end else begin
        if (r_hs) begin
          mem_if.rvalid = 1'b0;
          mem_if.rdata  = '0;
          s_pend = 0;
        end
        if (ar_hs) begin
          mem_if.arready = 1'b0;
          s_pend = 1; s_addr = a; s_arcnt = 0; s_rcnt = 0;
        end
        if (mem_if.arvalid && !mem_if.arready) begin
          if (s_arcnt >= ar_wait) mem_if.arready = 1'b1;
          else s_arcnt++;
        end
        if (s_pend && !mem_if.rvalid) begin
          if (s_rcnt >= r_wait) begin
            mem_if.rvalid = 1'b1;
            mem_if.rdata  = mem_data(s_addr);
            mem_if.rresp  = s_resp;
          end else begin
            s_rcnt++;
          end
        end
      end
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  bit          m_busy = 0, m_owner = 0, m_last = 0, m_ar_done = 0, m_r_got = 0;
  logic [31:0] m_addr = '0;
  logic [W-1:0] exp_q[$];
  bit          dut_grant_q[$];
  int          n_ar_raw = 0;

  function automatic bit winner(input bit iv, input bit lv);
`ifdef RD_ARB_RR_EN
    if (iv && lv) return ~m_last;
`endif
    return lv;
  endfunction

  initial begin
    bit iv, lv, w, rphase;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("rst_ifu_arready", ifu_if.arready, 0);
        chk("rst_lsu_arready", lsu_if.arready, 0);
        chk("rst_ifu_rvalid", ifu_if.rvalid, 0);
        chk("rst_lsu_rvalid", lsu_if.rvalid, 0);
        chk("rst_mem_arvalid", mem_if.arvalid, 0);
        chk("rst_mem_rready", mem_if.rready, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_owner", arb_owner, 0);
        m_busy = 0; m_owner = 0; m_last = 0; m_ar_done = 0; m_r_got = 0;
        exp_q.delete();
      end else begin
        iv = ifu_if.arvalid;
        lv = lsu_if.arvalid;
        rphase = m_busy && m_r_got;
        if (!m_busy && (iv || lv)) begin
          w = winner(iv, lv);
          chk("ifu_arready", ifu_if.arready, !w);
          chk("lsu_arready", lsu_if.arready, w);
        end else begin
          chk("ifu_arready_idle", ifu_if.arready, 0);
          chk("lsu_arready_idle", lsu_if.arready, 0);
        end
        chk("arb_busy", arb_busy, m_busy);
        chk("arb_owner", arb_owner, m_owner);
        chk("mem_arvalid", mem_if.arvalid, m_busy && !m_ar_done);
        if (m_busy && !m_ar_done) chk("mem_araddr", mem_if.araddr, m_addr);
        chk("mem_rready", mem_if.rready, m_busy && m_ar_done && !m_r_got);
        chk("ifu_rvalid", ifu_if.rvalid, rphase && !m_owner);
        chk("lsu_rvalid", lsu_if.rvalid, rphase && m_owner);
        if (rphase && exp_q.size() > 0) begin
          if (m_owner) chk("lsu_rdata", {lsu_if.rresp, lsu_if.rdata}, exp_q[0]);
          else         chk("ifu_rdata", {ifu_if.rresp, ifu_if.rdata}, exp_q[0]);
        end
        if (m_owner) chk("ifu_rdata_zero", {ifu_if.rresp, ifu_if.rdata}, '0);
        else         chk("lsu_rdata_zero", {lsu_if.rresp, lsu_if.rdata}, '0);

        if (ifu_if.arready) dut_grant_q.push_back(1'b0);
        if (lsu_if.arready) dut_grant_q.push_back(1'b1);
        if (mem_if.arvalid && mem_if.arready) n_ar_raw++;

        // Advance the model on the handshakes that complete at the next edge.
        if (!m_busy && (iv || lv)) begin
          w = winner(iv, lv);
          m_busy = 1; m_owner = w; m_last = w; m_ar_done = 0; m_r_got = 0;
          m_addr = w ? lsu_if.araddr : ifu_if.araddr;
        end else if (m_busy && !m_ar_done && mem_if.arready) begin
          m_ar_done = 1;
        end else if (m_busy && m_ar_done && !m_r_got && mem_if.rvalid) begin
          m_r_got = 1;
          exp_q.push_back({mem_if.rresp, mem_if.rdata});
        end else if (rphase && (m_owner ? lsu_if.rready : ifu_if.rready)) begin
          m_busy = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- requester driver tasks ----------------
  task automatic set_ar(input bit who, input bit v, input logic [31:0] a);
    if (who) begin lsu_if.arvalid = v; lsu_if.araddr = a; end
    else     begin ifu_if.arvalid = v; ifu_if.araddr = a; end
  endtask

  task automatic set_rready(input bit who, input bit v);
    if (who) lsu_if.rready = v;
    else     ifu_if.rready = v;
  endtask

  function automatic bit get_arready(input bit who);
    return who ? lsu_if.arready : ifu_if.arready;
  endfunction

  function automatic bit get_rvalid(input bit who);
    return who ? lsu_if.rvalid : ifu_if.rvalid;
  endfunction

  function automatic bit get_rready(input bit who);
    return who ? lsu_if.rready : ifu_if.rready;
  endfunction

  function automatic logic [W-1:0] get_r(input bit who);
    return who ? {lsu_if.rresp, lsu_if.rdata} : {ifu_if.rresp, ifu_if.rdata};
  endfunction

  // One read: returns accept cycle, first rvalid cycle, R handshake cycle, data.
  task automatic do_read(input bit who, input logic [31:0] addr, input int rdly,
                         output int t_acc, output int t_rv, output int t_hs,
                         output logic [W-1:0] got);
    int n;
    t_acc = -1; t_rv = -1; t_hs = -1; got = '0; n = 0;
    set_ar(who, 1'b1, addr);
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (get_arready(who)) begin t_acc = cyc; break; end
    end
    @(posedge clock);
    #1;
    set_ar(who, 1'b0, '0);
    if (t_acc < 0) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    if (rdly == 0) set_rready(who, 1'b1);
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (get_rvalid(who)) begin
        if (t_rv < 0) begin t_rv = cyc; got = get_r(who); end
        else chk("rdata_stable", get_r(who), got);
        if (get_rready(who)) begin t_hs = cyc; break; end
        n++;
        if (n >= rdly) begin
          @(posedge clock);
          #1;
          set_rready(who, 1'b1);
        end
      end
    end
    @(posedge clock);
    #1;
    set_rready(who, 1'b0);
    if (t_hs < 0) chk("response_timeout", 0, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int ta, tr, th, ta2, tr2, th2, base, ar0;
    logic [W-1:0] g, g2;
    bit exp_g[4];
    ifu_if.arvalid = 0; ifu_if.araddr = '0; ifu_if.rready = 0;
    lsu_if.arvalid = 0; lsu_if.araddr = '0; lsu_if.rready = 0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state", arb_state, IDLE);
    reset = 1'b1;

    // T1: IFU-only read, zero-wait slave.
    do_read(0, 32'h8000_0000, 0, ta, tr, th, g);
    chk("t1_latency", tr - ta, 3);
    chk("t1_data", g[63:0], 64'h0000_0013_0000_0093);
    chk("t1_resp", g[65:64], 2'b00);

    // T2: simultaneous IFU+LSU in IDLE; LSU first, IFU right after LSU R handshake.
    base = dut_grant_q.size();
    fork
      do_read(0, 32'h0000_1000, 0, ta, tr, th, g);
      do_read(1, 32'h0000_2000, 0, ta2, tr2, th2, g2);
    join
    chk("t2_first_grant_lsu", dut_grant_q.size() > base ? dut_grant_q[base] : 1'b0, 1'b1);
    chk("t2_ifu_accept_after_lsu", ta, th2 + 1);
    chk("t2_ifu_data", g[63:0], 64'hA5A5_1000_FFFF_EFFF);
    chk("t2_lsu_data", g2[63:0], 64'hA5A5_2000_FFFF_DFFF);

    // T3: both requesters re-issue back to back.
`ifdef RD_ARB_RR_EN
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    base = dut_grant_q.size();
    fork
      begin
        int a1, a2, a3; logic [W-1:0] d;
        for (int i = 0; i < 2; i++) do_read(0, 32'h0000_3000 + 32'(i * 4), 0, a1, a2, a3, d);
      end
      begin
        int b1, b2, b3; logic [W-1:0] d;
        for (int i = 0; i < 4; i++) do_read(1, 32'h0000_4000 + 32'(i * 4), 0, b1, b2, b3, d);
      end
    join
    chk("t3_grant_count", dut_grant_q.size() - base, 6);
    for (int i = 0; i < 4; i++)
      if (dut_grant_q.size() > base + i)
        chk($sformatf("t3_grant_%0d", i), dut_grant_q[base + i], exp_g[i]);

    // T4: slave stalls arready 5 cycles and rvalid 7 cycles.
    ar_wait = 5; r_wait = 7;
    ar0 = n_ar_raw;
    do_read(0, 32'h0000_5000, 0, ta, tr, th, g);
    chk("t4_single_ar", n_ar_raw - ar0, 1);
    chk("t4_latency", tr - ta, 15);
    chk("t4_data", g[63:0], 64'hA5A5_5000_FFFF_AFFF);
    ar_wait = 0; r_wait = 0;

    // T5: LSU backpressures R for 4 cycles while IFU waits; SLVERR passed through.
    s_resp = SLVERR;
    ar0 = n_ar_raw;
    fork
      do_read(1, 32'h0000_6000, 4, ta2, tr2, th2, g2);
      begin
        @(posedge clock);
        #1;
        do_read(0, 32'h0000_7000, 0, ta, tr, th, g);
      end
    join
    s_resp = OKAY;
    chk("t5_lsu_hold", th2 - tr2, 4);
    chk("t5_ifu_after_lsu", ta, th2 + 1);
    chk("t5_lsu_data", g2, {SLVERR, 64'hA5A5_6000_FFFF_9FFF});
    chk("t5_ifu_data", g, {SLVERR, 64'hA5A5_7000_FFFF_8FFF});
    chk("t5_ar_count", n_ar_raw - ar0, 2);

    // T6: reset during DATA, then a fresh read.
    r_wait = 7;
    set_ar(1, 1'b1, 32'h0000_9000);
    ta = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (lsu_if.arready) begin ta = cyc; break; end
    end
    @(posedge clock);
    #1;
    set_ar(1, 1'b0, '0);
    tr = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (mem_if.rready) begin tr = cyc; break; end
    end
    chk("t6_reached_data", (ta >= 0) && (tr >= 0), 1);
    chk("t6_owner_before", arb_owner, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_busy", arb_busy, 0);
    chk("t6_async_state", arb_state, IDLE);
    chk("t6_async_rready", mem_if.rready, 0);
    chk("t6_async_arvalid", mem_if.arvalid, 0);
    chk("t6_async_rvalid", {ifu_if.rvalid, lsu_if.rvalid}, 2'b00);
    chk("t6_async_owner", arb_owner, 0);
    r_wait = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    do_read(0, 32'h8000_0000, 0, ta, tr, th, g);
    chk("t6_after_latency", tr - ta, 3);
    chk("t6_after_data", g, {OKAY, 64'h0000_0013_0000_0093});

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
